// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 universe transmitter.
package dmx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAB,
        ST_FRAME,
        ST_FINISH
    } dmx_state_t;

    localparam logic [7:0] DMX_START_CODE = 8'h00;
    localparam int         DMX_FRAME_BITS = 11;
    localparam int         DMX_MAX_SLOTS  = 512;

    // Largest of three values; sizes the shared bit-index counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dmx_bit_timer.sv
// Bit-time divider: counts CLKS_PER_BIT clocks and flags the last cycle of each bit.
// Held at zero while cleared; load restarts the current bit time from its first cycle.
module dmx_bit_timer #(
    parameter int CLKS_PER_BIT = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    output logic bit_tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit counter that wraps at every bit boundary.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
        if (reset || clear || load) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/dmx_universe_tx.sv
// DMX512 packet transmitter: break, MAB, NULL start code, then slot data
// prefetched one byte ahead from the universe RAM.
module dmx_universe_tx
    import dmx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 200,
    parameter int BREAK_BITS   = 25,
    parameter int MAB_BITS     = 3,
    parameter int MAX_SLOTS    = DMX_MAX_SLOTS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [31:0]                  slot_count,
    output logic                         mem_rd_en,
    output logic [$clog2(MAX_SLOTS)-1:0] mem_addr,
    input  logic [7:0]                   mem_rdata,
    output logic                         dmx_tx,
    output logic                         dmx_tx_en,
    output logic                         busy,
    output logic                         done
);

    localparam int ADDR_W    = $clog2(MAX_SLOTS);
    localparam int BIT_CNT_W = $clog2(max3(BREAK_BITS, MAB_BITS, DMX_FRAME_BITS));

    localparam logic [BIT_CNT_W-1:0] BREAK_LAST = BIT_CNT_W'(BREAK_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] MAB_LAST   = BIT_CNT_W'(MAB_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] D7_IDX     = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] FRAME_LAST = BIT_CNT_W'(DMX_FRAME_BITS - 1);
    localparam logic [9:0]           SLOT_CAP   = 10'(MAX_SLOTS);

    dmx_state_t           state;
    logic [BIT_CNT_W-1:0] bit_cnt;     // bit index within the current phase or slot
    logic [9:0]           slot_cnt;    // slot being sent, 0 = start code
    logic [9:0]           count_q;     // clamped number of data slots
    logic [9:0]           shift_q;     // remaining slot bits, LSB goes out next
    logic [7:0]           hold_q;      // prefetched byte for the next slot
    logic                 rd_pending;  // RAM data arrives this cycle
    logic                 bit_tick;
    logic                 timer_clear;
    logic                 timer_load;

    assign timer_clear = (state == ST_IDLE) || (state == ST_FINISH);
    assign timer_load  = (state == ST_IDLE) && start;

    dmx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .load    (timer_load),
        .bit_tick(bit_tick)
    );

    // Packet sequencer: owns the line, the slot shifter, the prefetch and all status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            count_q    <= '0;
            shift_q    <= '1;
            hold_q     <= '0;
            rd_pending <= 1'b0;
            dmx_tx     <= 1'b1;
            dmx_tx_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
        end else begin
            // NOTE: strobes get a default here and are overridden below, so they self-clear after one cycle.
            mem_rd_en  <= 1'b0;
            done       <= 1'b0;
            rd_pending <= mem_rd_en;
            if (rd_pending) begin
                hold_q <= mem_rdata;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        count_q   <= (slot_count > 32'(MAX_SLOTS)) ? SLOT_CAP : slot_count[9:0];
                        state     <= ST_BREAK;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        dmx_tx_en <= 1'b1;
                        dmx_tx    <= 1'b0;
                    end
                end

                ST_BREAK: begin
                    if (bit_tick) begin
                        if (bit_cnt == BREAK_LAST) begin
                            state   <= ST_MAB;
                            bit_cnt <= '0;
                            dmx_tx  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_MAB: begin
                    if (bit_tick) begin
                        if (bit_cnt == MAB_LAST) begin
                            state    <= ST_FRAME;
                            bit_cnt  <= '0;
                            slot_cnt <= '0;
                            dmx_tx   <= 1'b0;
                            shift_q  <= {2'b11, DMX_START_CODE};
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_FRAME: begin
                    if (bit_tick) begin
                        if (bit_cnt == FRAME_LAST) begin
                            if (slot_cnt == count_q) begin
                                state     <= ST_FINISH;
                                busy      <= 1'b0;
                                dmx_tx_en <= 1'b0;
                                done      <= 1'b1;
                                dmx_tx    <= 1'b1;
                            end else begin
                                slot_cnt <= slot_cnt + 10'd1;
                                bit_cnt  <= '0;
                                dmx_tx   <= 1'b0;
                                shift_q  <= {2'b11, hold_q};
                            end
                        end else begin
                            dmx_tx  <= shift_q[0];
                            shift_q <= {1'b1, shift_q[9:1]};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            // Fetch the next slot's byte as this slot enters its first stop bit.
                            if (bit_cnt == D7_IDX && slot_cnt < count_q) begin
                                mem_rd_en <= 1'b1;
                                mem_addr  <= slot_cnt[ADDR_W-1:0];
                            end
                        end
                    end
                end

                ST_FINISH: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmx_universe_tx.sv
// Scoreboard bench for dmx_universe_tx: expected slots, reads and packet lengths are
// queued by the stimulus and retired by a line/RAM/done monitor.
module tb_dmx_universe_tx;
    import dmx_pkg::*;

    localparam int CPB      = 4;
    localparam int BRK      = 22;
    localparam int MAB      = 2;
    localparam int BRK_CYC  = CPB * BRK;
    localparam int MAB_CYC  = CPB * MAB;
    localparam int SLOT_CYC = CPB * DMX_FRAME_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] slot_count = 32'd0;
    logic        mem_rd_en;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dmx_tx;
    logic        dmx_tx_en;
    logic        busy;
    logic        done;

    logic [7:0]  ram [0:511];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] exp_slots[$];
    int         exp_addrs[$];
    int         exp_lens[$];

    int          idx = 0;
    int          lows = 0;
    int          highs = 0;
    int          pos = 0;
    logic [10:0] frame = '0;

    always #5 clk = ~clk;

    dmx_universe_tx #(
        .CLKS_PER_BIT(CPB),
        .BREAK_BITS  (BRK),
        .MAB_BITS    (MAB),
        .MAX_SLOTS   (512)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .slot_count(slot_count),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dmx_tx    (dmx_tx),
        .dmx_tx_en (dmx_tx_en),
        .busy      (busy),
        .done      (done)
    );

    // Universe RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: decodes the line at mid-bit, retires reads and packet completions.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_expected", int'(exp_lens.size() > 0), 1);
            if (exp_lens.size() > 0) begin
                check("busy_cycles", idx, exp_lens.pop_front());
                check("break_low_cycles", lows, BRK_CYC);
                check("mab_high_cycles", highs, MAB_CYC);
            end
            check("finish_busy", int'(busy), 0);
            check("finish_tx_en", int'(dmx_tx_en), 0);
            check("finish_tx", int'(dmx_tx), 1);
        end
        if (mem_rd_en) begin
            check("rd_expected", int'(exp_addrs.size() > 0), 1);
            if (exp_addrs.size() > 0) check("mem_addr", int'(mem_addr), exp_addrs.pop_front());
        end
        if (!busy) begin
            idx   = 0;
            lows  = 0;
            highs = 0;
        end else begin
            if (idx < BRK_CYC) begin
                if (!dmx_tx) lows++;
            end else if (idx < BRK_CYC + MAB_CYC) begin
                if (dmx_tx) highs++;
            end else begin
                pos = (idx - BRK_CYC - MAB_CYC) % SLOT_CYC;
                if (pos % CPB == CPB / 2) begin
                    frame[pos / CPB] = dmx_tx;
                    if (pos / CPB == DMX_FRAME_BITS - 1) begin
                        check("slot_framing", int'({frame[10:9], frame[0]}), 6);
                        check("slot_tx_en", int'(dmx_tx_en), 1);
                        check("slot_expected", int'(exp_slots.size() > 0), 1);
                        if (exp_slots.size() > 0) check("slot_data", int'(frame[8:1]), int'(exp_slots.pop_front()));
                    end
                end
            end
            idx++;
        end
    end

    task automatic expect_packet(input int n, input int len);
        exp_slots.push_back(DMX_START_CODE);
        for (int k = 1; k <= n; k++) begin
            exp_slots.push_back(ram[k-1]);
            exp_addrs.push_back(k - 1);
        end
        exp_lens.push_back(len);
    endtask

    task automatic pulse_start(input logic [31:0] cnt);
        @(negedge clk);
        slot_count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int dc0 = done_cnt;
        int waited = 0;
        while (done_cnt == dc0 && waited < budget) begin
            @(posedge clk);
            waited++;
        end
        repeat (8) @(posedge clk);
        check("done_count", done_cnt - dc0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int i = 0; i < 512; i++) ram[i] = 8'((i * 37 + 11) ^ (i >> 3));
        ram[0] = 8'hFF;
        ram[1] = 8'hA5;
        ram[2] = 8'h01;

        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", int'(dmx_tx), 1);
        check("rst_tx_en", int'(dmx_tx_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Three slots: 4*(22+2+11*4) = 272 busy cycles.
        exp_slots.push_back(8'h00);
        exp_slots.push_back(8'hFF);
        exp_slots.push_back(8'hA5);
        exp_slots.push_back(8'h01);
        exp_addrs.push_back(0);
        exp_addrs.push_back(1);
        exp_addrs.push_back(2);
        exp_lens.push_back(272);
        pulse_start(32'd3);
        wait_done(400);

        // Oversized count clamps to 512 data slots: 4*(24+11*513) = 22668.
        expect_packet(512, 22668);
        pulse_start(32'h0022_2222);
        wait_done(23000);

        // Zero slots: start code only, 4*(24+11) = 140.
        expect_packet(0, 140);
        pulse_start(32'd0);
        wait_done(300);

        // Start and slot_count changes mid-packet are ignored: 4*(24+22) = 184.
        expect_packet(1, 184);
        pulse_start(32'd1);
        repeat (40) @(posedge clk);
        pulse_start(32'd7);
        wait_done(400);
        repeat (300) @(negedge clk);
        check("repulse_idle", int'(busy), 0);

        // Start together with reset stays idle.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        slot_count = 32'd3;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", int'(busy), 0);
        check("rst_start_tx_en", int'(dmx_tx_en), 0);
        repeat (10) @(negedge clk);
        check("rst_start_idle", int'(busy), 0);

        // Reset during slot 2, data bit D3 (busy cycle 200).
        expect_packet(3, 272);
        pulse_start(32'd3);
        repeat (200) @(posedge clk);
        @(negedge clk);
        exp_slots.delete();
        exp_addrs.delete();
        exp_lens.delete();
        dc = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", int'(dmx_tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);

        // A normal packet after the abort.
        expect_packet(3, 272);
        pulse_start(32'd3);
        wait_done(400);

        check("leftover_slots", exp_slots.size(), 0);
        check("leftover_addrs", exp_addrs.size(), 0);
        check("leftover_lens", exp_lens.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
